// File: rtl/alu_pkg.sv
// Shared definitions for alu_multiciclo: op codes, FSM states and the single-cycle result mux.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_AND   = 4'd1;
    localparam logic [3:0] OP_XOR   = 4'd2;
    localparam logic [3:0] OP_SLL   = 4'd3;
    localparam logic [3:0] OP_SRA   = 4'd4;
    localparam logic [3:0] OP_SUB   = 4'd5;
    localparam logic [3:0] OP_JALR  = 4'd6;
    localparam logic [3:0] OP_ZERO7 = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_SRL   = 4'd9;
    localparam logic [3:0] OP_SLT   = 4'd10;
    localparam logic [3:0] OP_SLTU  = 4'd11;
    localparam logic [3:0] OP_MUL   = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_REMU  = 4'd14;
    localparam logic [3:0] OP_ZERO  = 4'd15;

    // The helper works on operands widened to XMAX; callers keep the low WIDTH bits.
    localparam int XMAX = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } alu_state_t;

    function automatic logic [XMAX-1:0] alu_fn(
        input logic [3:0]      op,
        input logic [XMAX-1:0] a_sx,
        input logic [XMAX-1:0] b_sx,
        input logic [XMAX-1:0] a_zx,
        input logic [XMAX-1:0] b_zx,
        input logic [5:0]      sh
    );
        logic [XMAX-1:0] r;
        r = '0;
        case (op)
            OP_ADD:  r = a_sx + b_sx;
            OP_AND:  r = a_sx & b_sx;
            OP_XOR:  r = a_sx ^ b_sx;
            OP_SLL:  r = a_sx << sh;
            OP_SRA:  r = $signed(a_sx) >>> sh;
            OP_SUB:  r = a_sx - b_sx;
            OP_JALR: r = (a_sx + b_sx) & ~{{(XMAX-1){1'b0}}, 1'b1};
            OP_OR:   r = a_sx | b_sx;
            OP_SRL:  r = a_zx >> sh;
            OP_SLT:  r = {{(XMAX-1){1'b0}}, ($signed(a_sx) < $signed(b_sx))};
            OP_SLTU: r = {{(XMAX-1){1'b0}}, (a_zx < b_zx)};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier and restoring divider, one step per cycle over WIDTH cycles.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             last
);

    logic          act;
    logic [CW-1:0] cnt;
    logic          is_div, is_rem;
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [WIDTH-1:0] rem, quo, dvsr;

    logic [WIDTH-1:0] acc_n, rem_n, quo_n;
    logic [WIDTH:0]   trial, diff;
    logic             ge;

    assign acc_n = acc + (mplier[0] ? mcand : '0);

    // trial < 2*dvsr always holds, so one extra bit is enough for the compare.
    // A zero divisor yields all-ones quotient and remainder = dividend naturally.
    assign trial = {rem, quo[WIDTH-1]};
    assign diff  = trial - {1'b0, dvsr};
    assign ge    = ~diff[WIDTH];
    assign rem_n = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_n = {quo[WIDTH-2:0], ge};

    // result is the value after the current step, so the top can latch it on the last edge
    assign result = is_rem ? rem_n : (is_div ? quo_n : acc_n);
    assign last   = act && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act    <= 1'b0;
            cnt    <= '0;
            is_div <= 1'b0;
            is_rem <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
        end else if (load) begin
            act    <= 1'b1;
            cnt    <= CW'(WIDTH-1);
            is_div <= (op == OP_DIVU);
            is_rem <= (op == OP_REMU);
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            rem    <= '0;
            quo    <= a;
            dvsr   <= b;
        end else if (act) begin
            acc    <= acc_n;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            rem    <= rem_n;
            quo    <= quo_n;
            cnt    <= cnt - 1'b1;
            if (cnt == '0)
                act <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_multiciclo.sv
// Registered execute-stage ALU with start/busy/done handshake.
// Define ALU_MULDIV_EN to enable the iterative mul/divu/remu unit.
module alu_multiciclo
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic [WIDTH-1:0] sal,
    output logic             busy,
    output logic             done
);

    logic [XMAX-1:0]  sc_full;
    logic [WIDTH-1:0] sc_res;
    logic             unused_sc;
    logic [WIDTH-1:0] sal_d;
    logic             done_d;

    assign sc_full = alu_fn(sel, XMAX'($signed(rs1)), XMAX'($signed(rs2)),
                            XMAX'(rs1), XMAX'(rs2), 6'(rs2[SHW-1:0]));
    assign sc_res    = sc_full[WIDTH-1:0];
    assign unused_sc = ^sc_full;

`ifdef ALU_MULDIV_EN
    alu_state_t       state_q, state_d;
    logic             md_load, md_last;
    logic [WIDTH-1:0] md_res;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_md (
        .clk    (clk),
        .rst    (rst),
        .load   (md_load),
        .op     (sel),
        .a      (rs1),
        .b      (rs2),
        .result (md_res),
        .last   (md_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        sal_d   = sal;
        done_d  = 1'b0;
        md_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (sel == OP_MUL) begin
                        state_d = ST_MUL;
                        md_load = 1'b1;
                    end else if (sel == OP_DIVU || sel == OP_REMU) begin
                        state_d = ST_DIV;
                        md_load = 1'b1;
                    end else begin
                        sal_d  = sc_res;
                        done_d = 1'b1;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (md_last) begin
                    sal_d   = md_res;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);
`else
    // ops 12-14 fall through the single-cycle mux and return zero
    always_comb begin
        sal_d  = sal;
        done_d = 1'b0;
        if (start) begin
            sal_d  = sc_res;
            done_d = 1'b1;
        end
    end

    assign busy = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sal  <= '0;
            done <= 1'b0;
        end else begin
            sal  <= sal_d;
            done <= done_d;
        end
    end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Self-checking bench for alu_multiciclo (WIDTH=32 plus a WIDTH=16 instance); honours ALU_MULDIV_EN.
module tb_alu_multiciclo;

`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  sel;
    logic [31:0] rs1, rs2, sal;
    logic        busy, done;

    logic        start16;
    logic [3:0]  sel16;
    logic [15:0] a16, b16, sal16;
    logic        busy16, done16;

    int tests = 0;
    int fails = 0;

    alu_multiciclo #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .sel(sel), .rs1(rs1), .rs2(rs2),
        .sal(sal), .busy(busy), .done(done)
    );

    alu_multiciclo #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sel(sel16), .rs1(a16), .rs2(b16),
        .sal(sal16), .busy(busy16), .done(done16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference straight from the op table, using plain 32-bit arithmetic.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] s;
        s = b[4:0];
        case (op)
            4'd0:  return a + b;
            4'd1:  return a & b;
            4'd2:  return a ^ b;
            4'd3:  return a << s;
            4'd4:  return $signed(a) >>> s;
            4'd5:  return a - b;
            4'd6:  return (a + b) & 32'hFFFF_FFFE;
            4'd8:  return a | b;
            4'd9:  return a >> s;
            4'd10: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd11: return (a < b) ? 32'd1 : 32'd0;
            4'd12: return MD ? a * b : 32'd0;
            4'd13: return !MD ? 32'd0 : (b == 0 ? 32'hFFFF_FFFF : a / b);
            4'd14: return !MD ? 32'd0 : (b == 0 ? a : a % b);
            default: return 32'd0;
        endcase
    endfunction

    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit noise);
        logic [31:0] exp;
        int n, bsy;
        bit iter;
        exp  = model(op, a, b);
        iter = MD && (op >= 4'd12) && (op <= 4'd14);
        @(negedge clk);
        start = 1'b1; sel = op; rs1 = a; rs2 = b;
        @(posedge clk); #1;
        start = 1'b0; sel = 4'($urandom); rs1 = $urandom; rs2 = $urandom;
        if (!iter) begin
            chk({tag, ".done"}, 32'(done), 32'd1);
            chk({tag, ".busy"}, 32'(busy), 32'd0);
            chk(tag, sal, exp);
        end else begin
            n = 0; bsy = 0;
            chk({tag, ".busy0"}, 32'(busy), 32'd1);
            while (!done && n < 64) begin
                if (busy) bsy++;
                if (noise) begin
                    @(negedge clk);
                    start = 1'($urandom); sel = 4'($urandom); rs1 = $urandom; rs2 = $urandom;
                end
                @(posedge clk); #1;
                n++;
            end
            start = 1'b0;
            chk({tag, ".lat"}, 32'(n), 32'd32);
            chk({tag, ".busycyc"}, 32'(bsy), 32'd32);
            chk({tag, ".busy"}, 32'(busy), 32'd0);
            chk(tag, sal, exp);
        end
    endtask

    task automatic idle_chk(input string tag, input logic [31:0] hold);
        @(posedge clk); #1;
        chk({tag, ".nodone"}, 32'(done), 32'd0);
        chk({tag, ".hold"}, sal, hold);
    endtask

    initial begin
        int dn, n;
        logic [3:0]  op;
        logic [31:0] a, b;
        rst = 1'b1; start = 1'b0; sel = '0; rs1 = '0; rs2 = '0;
        start16 = 1'b0; sel16 = '0; a16 = '0; b16 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.sal", sal, 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        @(negedge clk); rst = 1'b0;

        // async reset in the middle of a cycle, with done and sal non-zero
        do_op("pre", 4'd0, 32'h1234, 32'h1, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("arst.sal", sal, 32'd0);
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.done", 32'(done), 32'd0);
        @(negedge clk); rst = 1'b0;

        do_op("add5+7", 4'd0, 32'd5, 32'd7, 1'b0);
        chk("add5+7.const", sal, 32'd12);
        idle_chk("add.idle", 32'd12);

        do_op("sra", 4'd4, 32'h8000_0000, 32'd4, 1'b0);
        chk("sra.const", sal, 32'hF800_0000);
        do_op("srl", 4'd9, 32'h8000_0000, 32'd4, 1'b0);
        chk("srl.const", sal, 32'h0800_0000);
        do_op("slt", 4'd10, 32'hFFFF_FFFF, 32'd1, 1'b0);
        chk("slt.const", sal, 32'd1);
        do_op("sltu", 4'd11, 32'hFFFF_FFFF, 32'd1, 1'b0);
        chk("sltu.const", sal, 32'd0);
        do_op("jalr", 4'd6, 32'h1001, 32'h2, 1'b0);
        chk("jalr.const", sal, 32'h0000_1002);
        do_op("sll21", 4'd3, 32'h0000_0003, 32'h21, 1'b0);
        chk("sll21.const", sal, 32'h0000_0006);
        do_op("sub", 4'd5, 32'd3, 32'd5, 1'b0);
        chk("sub.const", sal, 32'hFFFF_FFFE);
        do_op("zero7", 4'd7, 32'hDEAD, 32'hBEEF, 1'b0);
        do_op("zero15", 4'd15, 32'hDEAD, 32'hBEEF, 1'b0);

        do_op("mul", 4'd12, 32'h0000_FFFF, 32'h0001_0001, 1'b1);
        if (MD) chk("mul.const", sal, 32'hFFFF_FFFF);
        else    chk("mul.off", sal, 32'd0);
        idle_chk("mul.idle", MD ? 32'hFFFF_FFFF : 32'd0);
        do_op("divu", 4'd13, 32'd100, 32'd7, 1'b0);
        do_op("remu", 4'd14, 32'd100, 32'd7, 1'b1);
        do_op("divu0", 4'd13, 32'h1234_5678, 32'd0, 1'b0);
        do_op("remu0", 4'd14, 32'd9, 32'd0, 1'b0);
        // back-to-back: the next start lands in the done cycle
        do_op("b2b", 4'd8, 32'hF0F0_0000, 32'h0000_0F0F, 1'b0);

        if (MD) begin
            @(negedge clk);
            start = 1'b1; sel = 4'd12; rs1 = 32'h1234; rs2 = 32'h5678;
            @(posedge clk); #1 start = 1'b0;
            repeat (10) @(posedge clk);
            #2 rst = 1'b1;
            #1;
            chk("mulrst.busy", 32'(busy), 32'd0);
            chk("mulrst.sal", sal, 32'd0);
            @(negedge clk); rst = 1'b0;
            dn = 0;
            repeat (40) begin
                @(posedge clk); #1;
                if (done) dn++;
            end
            chk("mulrst.nodone", 32'(dn), 32'd0);
            chk("mulrst.idle", 32'(busy), 32'd0);
            do_op("mulrst.add", 4'd0, 32'd40, 32'd2, 1'b0);
        end

        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            do_op($sformatf("rnd%0d", i), op, a, b, 1'($urandom));
            if ($urandom_range(0, 1) == 1) idle_chk($sformatf("rnd%0d.idle", i), model(op, a, b));
        end

        // 16-bit instance: wrap-around and op 12 behaviour
        @(negedge clk);
        start16 = 1'b1; sel16 = 4'd0; a16 = 16'hFFFF; b16 = 16'h0001;
        @(posedge clk); #1 start16 = 1'b0;
        chk("w16.add.done", 32'(done16), 32'd1);
        chk("w16.add", 32'(sal16), 32'd0);
        @(negedge clk);
        start16 = 1'b1; sel16 = 4'd12; a16 = 16'h00FF; b16 = 16'h0101;
        @(posedge clk); #1 start16 = 1'b0;
        n = 1;
        if (MD) begin
            chk("w16.mul.busy", 32'(busy16), 32'd1);
            while (!done16 && n < 64) begin
                @(posedge clk); #1;
                n++;
            end
            chk("w16.mul.lat", 32'(n), 32'd17);
            chk("w16.mul", 32'(sal16), 32'hFFFF);
        end else begin
            chk("w16.mul.done", 32'(done16), 32'd1);
            chk("w16.mul.busy", 32'(busy16), 32'd0);
            chk("w16.mul", 32'(sal16), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
